ex_issue: RTL and testbench

ID/EX issue stage of the toy MIPS pipeline. It sits directly upstream of the EX logic/arithmetic units. It registers the decoded instruction and resolves source operands through EX/MEM forwarding. It also detects load-use hazards, inserts bubbles, and drives `alu_en`/`op`/`srcl`/`srcr` into the EX units one cycle after acceptance. It back-pressures the decoder via `id_stall` and keeps a saturating stall-cycle counter.

---
 rtl/ex_issue.sv | 86 ++++++++
 tb/tb_ex_issue.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ex_issue.sv
// ex_issue: ID/EX issue stage with operand forwarding, load-use interlock and stall counter.
// Define ISSUE_FWD_EN to enable EX/MEM forwarding; otherwise every pending-write read interlocks.
module ex_issue #(
   parameter int OP_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [OP_W-1:0] id_op,
   input  logic [4:0]      id_rs_addr,
   input  logic [4:0]      id_rt_addr,
   input  logic [31:0]     id_rs_data,
   input  logic [31:0]     id_rt_data,
   input  logic [31:0]     id_imm,
   input  logic            id_use_imm,
   input  logic            id_wreg,
   input  logic [4:0]      id_waddr,
   input  logic            id_is_load,
   input  logic [31:0]     ex_fwd_data,
   input  logic            mem_wreg,
   input  logic [4:0]      mem_waddr,
   input  logic [31:0]     mem_wdata,
   input  logic            ex_hold,
   input  logic            flush,
   output logic            id_stall,
   output logic            alu_en,
   output logic [OP_W-1:0] op,
   output logic [31:0]     srcl,
   output logic [31:0]     srcr,
   output logic            ex_wreg,
   output logic [4:0]      ex_waddr,
   output logic            ex_is_load,
   output logic [15:0]     stall_cnt
);
   logic        rs_rd, rt_rd, rs_zero, rt_zero;
   logic        rs_ex, rt_ex, rs_mem, rt_mem;
   logic        load_use, issue;
   logic [31:0] rs_val, rt_val;
   assign rs_rd   = id_valid;
   assign rt_rd   = id_valid & ~id_use_imm;
   assign rs_zero = id_rs_addr == 5'd0;
   assign rt_zero = id_rt_addr == 5'd0;
   // register 0 never matches a pending write, so it can neither hazard nor forward
   assign rs_ex  = ex_wreg & (ex_waddr == id_rs_addr) & ~rs_zero;
   assign rt_ex  = ex_wreg & (ex_waddr == id_rt_addr) & ~rt_zero;
   assign rs_mem = mem_wreg & (mem_waddr == id_rs_addr) & ~rs_zero;
   assign rt_mem = mem_wreg & (mem_waddr == id_rt_addr) & ~rt_zero;
`ifdef ISSUE_FWD_EN
   assign load_use = ex_is_load & ((rs_rd & rs_ex) | (rt_rd & rt_ex));
   assign rs_val = rs_zero ? 32'd0 : (rs_ex & ~ex_is_load) ? ex_fwd_data : rs_mem ? mem_wdata : id_rs_data;
   assign rt_val = rt_zero ? 32'd0 : (rt_ex & ~ex_is_load) ? ex_fwd_data : rt_mem ? mem_wdata : id_rt_data;
`else
   logic unused_fwd;
   assign unused_fwd = ^{ex_fwd_data, mem_wdata};
   assign load_use = (rs_rd & (rs_ex | rs_mem)) | (rt_rd & (rt_ex | rt_mem));
   assign rs_val = rs_zero ? 32'd0 : id_rs_data;
   assign rt_val = rt_zero ? 32'd0 : id_rt_data;
`endif
   assign issue    = id_valid & ~load_use;
   assign id_stall = ~rst & ~flush & (ex_hold | load_use);
   always_ff @(posedge clk) begin
      if (rst | flush | (~ex_hold & ~issue)) begin
         alu_en     <= 1'b0;
         op         <= '0;
         srcl       <= 32'd0;
         srcr       <= 32'd0;
         ex_wreg    <= 1'b0;
         ex_waddr   <= 5'd0;
         ex_is_load <= 1'b0;
      end else if (~ex_hold) begin
         alu_en     <= 1'b1;
         op         <= id_op;
         srcl       <= rs_val;
         srcr       <= id_use_imm ? id_imm : rt_val;
         ex_wreg    <= id_wreg;
         ex_waddr   <= id_waddr;
         ex_is_load <= id_is_load;
      end
   end
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= 16'd0;
      else if (id_stall & ~&stall_cnt)
         stall_cnt <= stall_cnt + 16'd1;
   end
endmodule

// File: tb/tb_ex_issue.sv
// tb_ex_issue: table-driven directed checks of ex_issue plus hold-saturation sequence.
module tb_ex_issue;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [7:0]  id_op = '0;
   logic [4:0]  id_rs_addr = '0, id_rt_addr = '0, id_waddr = '0, mem_waddr = '0;
   logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, ex_fwd_data = '0, mem_wdata = '0;
   logic        id_use_imm = 1'b0, id_wreg = 1'b0, id_is_load = 1'b0, mem_wreg = 1'b0;
   logic        ex_hold = 1'b0, flush = 1'b0;
   logic        id_stall, alu_en, ex_wreg, ex_is_load;
   logic [7:0]  op;
   logic [31:0] srcl, srcr;
   logic [4:0]  ex_waddr;
   logic [15:0] stall_cnt;
   int          checks = 0;
   int          errors = 0;
   int          row = 0;
   logic [15:0] cnt_model = 16'd0;

   always #5 clk = ~clk;

   ex_issue #(.OP_W(8)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_use_imm(id_use_imm), .id_wreg(id_wreg), .id_waddr(id_waddr),
      .id_is_load(id_is_load), .ex_fwd_data(ex_fwd_data),
      .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .ex_hold(ex_hold), .flush(flush), .id_stall(id_stall), .alu_en(alu_en),
      .op(op), .srcl(srcl), .srcr(srcr), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
      .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic        rst, flush, hold, valid;
      logic [7:0]  op;
      logic [4:0]  rs, rt;
      logic [31:0] rsd, rtd, imm;
      logic        ui, wr;
      logic [4:0]  wa;
      logic        ld;
      logic [31:0] fwd;
      logic        mw;
      logic [4:0]  mwa;
      logic [31:0] mwd;
      logic        e_stall, e_en;
      logic [7:0]  e_op;
      logic [31:0] e_l, e_r;
      logic        e_w;
      logic [4:0]  e_wa;
      logic        e_ld;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic rs_t, fl, hd, vl, input logic [7:0] o, input logic [4:0] rs, rt,
      input logic [31:0] rsd, rtd, imm, input logic ui, wr, input logic [4:0] wa, input logic ld,
      input logic [31:0] fwd, input logic mw, input logic [4:0] mwa, input logic [31:0] mwd,
      input logic s, en, input logic [7:0] eop, input logic [31:0] el, er,
      input logic ew, input logic [4:0] ewa, input logic eld);
      vec_t v;
      v.rst = rs_t; v.flush = fl; v.hold = hd; v.valid = vl; v.op = o; v.rs = rs; v.rt = rt;
      v.rsd = rsd; v.rtd = rtd; v.imm = imm; v.ui = ui; v.wr = wr; v.wa = wa; v.ld = ld;
      v.fwd = fwd; v.mw = mw; v.mwa = mwa; v.mwd = mwd;
      v.e_stall = s; v.e_en = en; v.e_op = eop; v.e_l = el; v.e_r = er;
      v.e_w = ew; v.e_wa = ewa; v.e_ld = eld;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; flush = v.flush; ex_hold = v.hold; id_valid = v.valid; id_op = v.op;
      id_rs_addr = v.rs; id_rt_addr = v.rt; id_rs_data = v.rsd; id_rt_data = v.rtd;
      id_imm = v.imm; id_use_imm = v.ui; id_wreg = v.wr; id_waddr = v.wa; id_is_load = v.ld;
      ex_fwd_data = v.fwd; mem_wreg = v.mw; mem_waddr = v.mwa; mem_wdata = v.mwd;
   endtask

   initial begin
      // reset held two cycles while the decoder presents an instruction
      vq.push_back(mk(1,0,0,1,8'h21,1,2,32'h5,32'hB,0,0,1,3,0,0,0,0,0, 0,0,0,0,0,0,0,0));
      vq.push_back(mk(1,0,0,1,8'h21,1,2,32'h5,32'hB,0,0,1,3,0,0,0,0,0, 0,0,0,0,0,0,0,0));
      vq.push_back(mk(0,0,0,1,8'h21,1,2,32'h5,32'hB,0,0,1,3,0,0,0,0,0, 0,1,8'h21,32'h5,32'hB,1,3,0));
`ifdef ISSUE_FWD_EN
      vq.push_back(mk(0,0,0,1,8'h25,3,4,32'hDEAD,32'h7,0,0,1,6,0,32'h10,0,0,0, 0,1,8'h25,32'h10,32'h7,1,6,0));
`else
      vq.push_back(mk(0,0,0,1,8'h25,3,4,32'hDEAD,32'h7,0,0,1,6,0,32'h10,0,0,0, 1,0,0,0,0,0,0,0));
      vq.push_back(mk(0,0,0,1,8'h25,3,4,32'hDEAD,32'h7,0,0,1,6,0,32'h10,1,3,32'h10, 1,0,0,0,0,0,0,0));
      vq.push_back(mk(0,0,0,1,8'h25,3,4,32'h10,32'h7,0,0,1,6,0,32'h10,0,0,0, 0,1,8'h25,32'h10,32'h7,1,6,0));
`endif
      // lw $5 followed by a reader of $5
      vq.push_back(mk(0,0,0,1,8'h23,1,0,32'h100,0,32'h4,1,1,5,1,0,0,0,0, 0,1,8'h23,32'h100,32'h4,1,5,1));
      vq.push_back(mk(0,0,0,1,8'h24,5,2,32'hAAAA,32'hF,0,0,1,7,0,0,0,0,0, 1,0,0,0,0,0,0,0));
`ifdef ISSUE_FWD_EN
      vq.push_back(mk(0,0,0,1,8'h24,5,2,32'hAAAA,32'hF,0,0,1,7,0,0,1,5,32'h1234, 0,1,8'h24,32'h1234,32'hF,1,7,0));
`else
      vq.push_back(mk(0,0,0,1,8'h24,5,2,32'hAAAA,32'hF,0,0,1,7,0,0,1,5,32'h1234, 1,0,0,0,0,0,0,0));
      vq.push_back(mk(0,0,0,1,8'h24,5,2,32'h1234,32'hF,0,0,1,7,0,0,0,0,0, 0,1,8'h24,32'h1234,32'hF,1,7,0));
`endif
      // load to $0 then a reader of $0
      vq.push_back(mk(0,0,0,1,8'h23,1,0,32'h100,0,32'h8,1,1,0,1,0,0,0,0, 0,1,8'h23,32'h100,32'h8,1,0,1));
      vq.push_back(mk(0,0,0,1,8'h25,0,0,32'h5555,32'h6666,0,0,1,8,0,0,0,0,0, 0,1,8'h25,0,0,1,8,0));
      for (int i = 0; i < 3; i++)
         vq.push_back(mk(0,0,1,1,8'h21,1,2,32'h9,32'h9,0,0,1,9,0,0,0,0,0, 1,1,8'h25,0,0,1,8,0));
      vq.push_back(mk(0,1,1,1,8'h21,1,2,32'h9,32'h9,0,0,1,9,0,0,0,0,0, 0,0,0,0,0,0,0,0));
      vq.push_back(mk(0,1,0,1,8'h21,1,2,32'h9,32'h9,0,0,1,9,0,0,0,0,0, 0,0,0,0,0,0,0,0));
      // reset arriving during a load-use stall discards it
      vq.push_back(mk(0,0,0,1,8'h23,1,0,32'h100,0,32'h4,1,1,5,1,0,0,0,0, 0,1,8'h23,32'h100,32'h4,1,5,1));
      vq.push_back(mk(1,0,0,1,8'h24,5,2,32'hAAAA,32'hF,0,0,1,7,0,0,0,0,0, 0,0,0,0,0,0,0,0));
      vq.push_back(mk(0,0,0,1,8'h24,5,2,32'hAAAA,32'hF,0,0,1,7,0,0,0,0,0, 0,1,8'h24,32'hAAAA,32'hF,1,7,0));
      // immediate form does not read rt, so the pending load to $5 is no hazard
      vq.push_back(mk(0,0,0,1,8'h23,1,0,32'h100,0,32'h4,1,1,5,1,0,0,0,0, 0,1,8'h23,32'h100,32'h4,1,5,1));
      vq.push_back(mk(0,0,0,1,8'h21,1,5,32'h30,32'hBAD,32'h20,1,1,9,0,0,0,0,0, 0,1,8'h21,32'h30,32'h20,1,9,0));
      vq.push_back(mk(0,0,0,0,8'h21,9,9,32'h1,32'h1,0,0,1,9,0,0,0,0,0, 0,0,0,0,0,0,0,0));

      foreach (vq[k]) begin
         row = k;
         @(negedge clk);
         drive(vq[k]);
         #1 chk("id_stall", {31'd0, id_stall}, {31'd0, vq[k].e_stall});
         @(posedge clk);
         cnt_model = vq[k].rst ? 16'd0 : (vq[k].e_stall && cnt_model != 16'hFFFF) ? cnt_model + 16'd1 : cnt_model;
         #1;
         chk("alu_en", {31'd0, alu_en}, {31'd0, vq[k].e_en});
         chk("op", {24'd0, op}, {24'd0, vq[k].e_op});
         chk("srcl", srcl, vq[k].e_l);
         chk("srcr", srcr, vq[k].e_r);
         chk("ex_wreg", {31'd0, ex_wreg}, {31'd0, vq[k].e_w});
         chk("ex_waddr", {27'd0, ex_waddr}, {27'd0, vq[k].e_wa});
         chk("ex_is_load", {31'd0, ex_is_load}, {31'd0, vq[k].e_ld});
         chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, cnt_model});
      end

      // long hold saturates the counter
      row = vq.size();
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; ex_hold = 1'b1; id_valid = 1'b0;
      repeat (70000) @(posedge clk);
      #1;
      chk("sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
      chk("sat_stall", {31'd0, id_stall}, 32'd1);
      chk("sat_alu_en", {31'd0, alu_en}, 32'd0);
      @(posedge clk);
      #1 chk("sat_stick", {16'd0, stall_cnt}, 32'h0000FFFF);
      @(negedge clk);
      rst = 1'b1; ex_hold = 1'b0;
      @(posedge clk);
      #1 chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
